// File: rtl/jg_seq_defs.sv
// Shared definitions for the Johnson/Gray sequencer: state encoding,
// the all-zero Johnson code and a legality check for 4-bit Johnson codes.
package jg_seq_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RECOVER = 2'd3
    } seq_state_t;

    localparam logic [3:0] JOHNSON_ZERO = 4'b0000;

    // A 4-bit Johnson counter only ever visits these eight codes.
    function automatic logic is_legal_johnson(input logic [3:0] code);
        case (code)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/johnson_gray_seq_conv.sv
// johnson_to_gray: combinational 4-bit Johnson to 3-bit Gray converter.
// Four interchangeable realizations selected by REALIZATION:
//   "MDNF"    minimal sum-of-products
//   "Case"    lookup table (illegal codes map to 000)
//   "PIRS"    NOR-only network
//   "SHEFFER" NAND-only network
// For legal codes all four agree: gray = {j[3], j[1], j[0] ^ j[2]}.
module johnson_to_gray #(
    parameter string REALIZATION = "MDNF"
) (
    input  logic [3:0] johnson,
    output logic [2:0] gray
);

    if (REALIZATION == "Case") begin : g_case
        // Table lookup over the eight legal codes.
        always_comb begin
            gray = 3'b000;
            case (johnson)
                4'b0000: gray = 3'b000;
                4'b0001: gray = 3'b001;
                4'b0011: gray = 3'b011;
                4'b0111: gray = 3'b010;
                4'b1111: gray = 3'b110;
                4'b1110: gray = 3'b111;
                4'b1100: gray = 3'b101;
                4'b1000: gray = 3'b100;
                default: gray = 3'b000;
            endcase
        end
    end else if (REALIZATION == "PIRS") begin : g_nor
        logic n1, n2, n3, xn, nj1, nj3;
        assign n1      = ~(johnson[0] | johnson[2]);
        assign n2      = ~(johnson[0] | n1);
        assign n3      = ~(johnson[2] | n1);
        assign xn      = ~(n2 | n3);
        assign nj1     = ~(johnson[1] | johnson[1]);
        assign nj3     = ~(johnson[3] | johnson[3]);
        assign gray[0] = ~(xn | xn);
        assign gray[1] = ~(nj1 | nj1);
        assign gray[2] = ~(nj3 | nj3);
    end else if (REALIZATION == "SHEFFER") begin : g_nand
        logic m, p, q, nj1, nj3;
        assign m       = ~(johnson[0] & johnson[2]);
        assign p       = ~(johnson[0] & m);
        assign q       = ~(johnson[2] & m);
        assign nj1     = ~(johnson[1] & johnson[1]);
        assign nj3     = ~(johnson[3] & johnson[3]);
        assign gray[0] = ~(p & q);
        assign gray[1] = ~(nj1 & nj1);
        assign gray[2] = ~(nj3 & nj3);
    end else begin : g_mdnf
        assign gray[0] = (johnson[0] & ~johnson[2]) | (~johnson[0] & johnson[2]);
        assign gray[1] = johnson[1];
        assign gray[2] = johnson[3];
    end

endmodule

// File: rtl/johnson_gray_seq.sv
// johnson_gray_seq: steps a 4-bit Johnson counter forward/backward every
// STEP_DIV clocks and offers each new code, with its Gray translation, on a
// valid/ready output. Illegal loaded codes are flushed back to 0000.
// Optional build macro JG_SEQ_CROSSCHECK_EN adds a "Case" shadow converter
// and a sticky xchk_err output.
//
// Handshake: out_valid rises with a new code and stays high, with johnson
// and gray held, until a cycle in which out_ready=1; that cycle consumes the
// code and out_valid falls on the following edge.
module johnson_gray_seq
    import jg_seq_defs::*;
#(
    parameter string REALIZATION = "MDNF",
    parameter int    STEP_DIV    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] johnson,
    output logic [2:0] gray,
    output logic       wrap,
    output logic       busy,
`ifdef JG_SEQ_CROSSCHECK_EN
    output logic       xchk_err,
`endif
    output logic       err_illegal
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

    seq_state_t    state;
    logic [PW-1:0] prescale;
    logic          stop_pending;
    logic [3:0]    j_next;

    // Next Johnson code in the requested direction; dir only matters on a step.
    assign j_next = dir ? {~johnson[0], johnson[3:1]}
                        : {johnson[2:0], ~johnson[3]};

    assign busy = (state != ST_IDLE);

    johnson_to_gray #(.REALIZATION(REALIZATION)) u_conv (
        .johnson (johnson),
        .gray    (gray)
    );

    // Sequencer FSM: all outputs except gray/busy are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            johnson      <= JOHNSON_ZERO;
            out_valid    <= 1'b0;
            wrap         <= 1'b0;
            err_illegal  <= 1'b0;
            prescale     <= '0;
            stop_pending <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        johnson <= load_val;
                        if (!is_legal_johnson(load_val)) state <= ST_RECOVER;
                    end else if (start && !stop) begin
                        prescale    <= '0;
                        err_illegal <= 1'b0;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (prescale == PRE_LAST) begin
                        johnson   <= j_next;
                        prescale  <= '0;
                        out_valid <= 1'b1;
                        wrap      <= (j_next == JOHNSON_ZERO);
                        state     <= ST_WAIT;
                    end else begin
                        prescale <= prescale + PW'(1);
                    end
                end
                ST_WAIT: begin
                    // A stop arriving together with out_ready is honoured too.
                    if (out_ready) begin
                        out_valid    <= 1'b0;
                        stop_pending <= 1'b0;
                        state        <= (stop_pending || stop) ? ST_IDLE : ST_RUN;
                    end else if (stop) begin
                        stop_pending <= 1'b1;
                    end
                end
                ST_RECOVER: begin
                    johnson     <= JOHNSON_ZERO;
                    err_illegal <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef JG_SEQ_CROSSCHECK_EN
    logic [2:0] gray_chk;

    johnson_to_gray #(.REALIZATION("Case")) u_conv_chk (
        .johnson (johnson),
        .gray    (gray_chk)
    );

    // Sticky disagreement flag between the main and shadow converters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xchk_err <= 1'b0;
        end else if (out_valid && (gray_chk != gray)) begin
            xchk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/johnson_gray_seq.md
Name: johnson_gray_seq

Overview:
Sequencer for the Johnson-to-Gray converter. Holds a 4-bit Johnson counter, steps it forward or backward at a programmable rate, and presents each Johnson code with its Gray translation on a valid/ready output. Detects and recovers from illegal Johnson codes. Sits between the control/config logic and any consumer of the Gray position stream.

Parameters:
REALIZATION, "MDNF", converter implementation passed to the sub-instance: "MDNF", "Case", "PIRS" or "SHEFFER".
STEP_DIV, 1, clock cycles per step while running; legal range 1..256; prescaler width is $clog2(STEP_DIV), minimum 1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin stepping; clears err_illegal
stop  input  1  halt stepping
dir  input  1  0 = forward (j <= {j[2:0], ~j[3]}); 1 = reverse (j <= {~j[0], j[3:1]})
load  input  1  load load_val into the counter; honoured in IDLE only
load_val  input  4  Johnson code to load
out_ready  input  1  consumer accepts the current code
out_valid  output  1  johnson/gray hold a new, unconsumed code
johnson  output  4  current counter value (registered)
gray  output  3  combinational converter output for johnson
wrap  output  1  one-cycle pulse on the step that produces 4'b0000
busy  output  1  high in any state other than IDLE
err_illegal  output  1  sticky flag: an illegal code was loaded

Behaviour:
- Reset (async, rst_n=0): state IDLE, johnson=4'b0000, out_valid=0, wrap=0, err_illegal=0, prescaler=0.
- Legal codes: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000. All other 8 codes are illegal.
- IDLE:
  - load=1: johnson<=load_val. If load_val is illegal, go to RECOVER.
  - start=1 with stop=0: prescaler<=0, err_illegal<=0, go to RUN.
  - start and stop in the same cycle: stay in IDLE.
  - load has priority over start; a start issued in a load cycle is ignored.
- RUN:
  - stop=1: go to IDLE next cycle; no step in that cycle.
  - Otherwise the prescaler increments. When it equals STEP_DIV-1:
    - johnson<=next(dir), prescaler<=0, out_valid<=1, go to WAIT.
    - wrap<=1 for one cycle if next(dir)==4'b0000.
  - With STEP_DIV=1 the step fires on the first RUN cycle.
- WAIT:
  - out_valid=1; johnson is held stable; the prescaler is frozen.
  - stop during WAIT is latched.
  - out_ready=1: out_valid<=0; go to IDLE if a stop is latched, otherwise RUN. The latch clears on that transition.
  - Handshake completes in the same cycle out_ready is seen; minimum spacing between steps is STEP_DIV+1 cycles.
- RECOVER: one cycle; johnson<=4'b0000, err_illegal<=1, out_valid stays 0; return to IDLE.
- Wrap-around: forward 1000 -> 0000; reverse 0001 -> 0000. dir is sampled only in the step cycle, so changing it mid-prescale is legal.
- gray follows johnson combinationally through the converter (zero added latency); it is valid whenever out_valid=1.
- Reset mid-WAIT drops out_valid immediately (asynchronously); the unconsumed code is discarded.

Optional Feature:
Macro JG_SEQ_CROSSCHECK_EN.
- Defined: a second converter instance using "Case" is compared against the main instance. On any mismatch while out_valid=1, adds output xchk_err (1 bit, sticky, cleared by reset only).
- Not defined: no second instance, no xchk_err port; area and behaviour otherwise identical.

Decomposition:
- Shared include/package (jg_seq_defs): state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_WAIT=2'd2, ST_RECOVER=2'd3; the JOHNSON_ZERO constant; an is_legal_johnson function.
- One sub-module: the existing johnson_to_gray converter, instantiated with #(REALIZATION). The next-code logic stays inline.

Test Plan:
- Reset, then start with dir=0, STEP_DIV=1, out_ready=1 -> johnson steps 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 with gray 001, 011, 010, 110, 111, 101, 100, 000; wrap pulses with 0000; steps 2 cycles apart.
- dir=1 from 0000 -> 1000/100, 1100/101, ..., 0001/001, 0000/000; wrap pulses on 0001 -> 0000.
- STEP_DIV=4, out_ready=0 for 10 cycles after the first step -> johnson held at 0001, out_valid=1 throughout; the next step occurs 4 cycles after out_ready rises.
- load_val=4'b0101 in IDLE -> RECOVER one cycle, johnson=0000, err_illegal=1; a following start clears it. load_val=4'b0111 -> johnson=0111, err_illegal stays 0.
- stop during WAIT, then out_ready=1 -> out_valid drops and busy=0 the next cycle; no further steps occur.
- rst_n pulled low while out_valid=1 -> out_valid=0 and johnson=0000 immediately, without waiting for a clock edge.
